serial_sum_collector: RTL and testbench
=======================================

Name: serial_sum_collector

Overview:
Downstream stage of the bit-serial adder datapath. Each cycle it consumes the adder's sum (s) and carry (c) outputs and deserialises the sum stream, LSB first, into a WIDTH-bit parallel result. It also tallies carry events and flags word completion. The carry tally feeds the multiplier's partial-product accumulation and the top-level io_out readback.

Parameters:
WIDTH, 8, number of serial sum bits per word; legal range 2..16
CW, $clog2(WIDTH+1), width of bit_count and carry_count (derived; not overridable)

Ports:
clk  input  1  sole clock, rising-edge
reset  input  1  synchronous, active-high; sampled on rising clk
start  input  1  begin a new word; clears the accumulator
bit_valid  input  1  s_in/c_in carry a valid bit this cycle
s_in  input  1  sum bit from the adder stage
c_in  input  1  carry bit from the adder stage
ack  input  1  consumer acknowledges a completed word
result  output  WIDTH  deserialised sum word, bit 0 = first bit received
last_carry  output  1  c_in captured with the final (WIDTH-th) bit
carry_count  output  CW  number of accepted bits whose c_in was 1
bit_count  output  CW  bits accepted in the current word
busy  output  1  high in CAPTURE
done  output  1  high in DONE

Behaviour:
- Single clock domain; all state updates on rising clk. No combinational path from inputs to outputs; every output is registered or decoded from state.
- reset=1 at a clock edge gives: state=IDLE, result=0, last_carry=0, carry_count=0, bit_count=0, busy=0, done=0. Reset overrides all other inputs, including during CAPTURE or DONE.
- States:
  - IDLE:
    - start=1 -> CAPTURE; clear result, bit_count, carry_count and last_carry.
    - bit_valid is ignored.
  - CAPTURE:
    - Each cycle with bit_valid=1:
      - result <= {s_in, result[WIDTH-1:1]}, a right shift so the first bit lands in bit 0 after WIDTH shifts.
      - bit_count += 1.
      - carry_count += c_in.
    - On the cycle bit_valid=1 and bit_count==WIDTH-1: last_carry <= c_in; next state is DONE.
    - bit_valid=0: hold all registers. Stalls may be of any length.
  - DONE:
    - result, last_carry, carry_count hold; bit_count reads WIDTH.
    - ack=1 -> IDLE; outputs keep their values until the next start.
    - start=1 (with or without ack) -> CAPTURE with registers cleared. start wins over ack.
    - bit_valid is ignored.
- start=1 while in CAPTURE aborts the word:
  - All accumulators are cleared and CAPTURE restarts.
  - bit_valid in that same cycle is NOT accepted.
- start and bit_valid together in IDLE: the bit is dropped; capture begins on the next cycle.
- Latency: done rises on the clock edge that accepts the WIDTH-th bit. result is valid in the same cycle done is first high.
- carry_count saturates naturally at WIDTH; no wrap is possible.
- busy and done are mutually exclusive; both are low in IDLE.
- Any unreachable state encoding recovers to IDLE on the next edge.

Test Plan:
- Reset mid-word: WIDTH=4, start, accept 2 bits, then pulse reset -> next cycle result=0, bit_count=0, carry_count=0, busy=0, done=0.
- Basic word: WIDTH=4, start, then s_in=1,0,1,1 and c_in=0,1,0,1 on 4 consecutive bit_valid cycles -> result=4'hD, carry_count=2, last_carry=1, done=1 on the 4th accept edge; ack -> IDLE with result still 4'hD.
- Stalls: the same stream with bit_valid=0 inserted for 3 cycles between bits 2 and 3 -> identical result 4'hD; busy stays 1 throughout; done only after the 4th valid bit.
- Abort/restart: start, accept s_in=1,1; assert start with bit_valid=1 and s_in=1, then feed 0,0,0,1 -> result=4'h8, bit_count reached 4, the aborting-cycle bit is not counted.
- Back-to-back: in DONE assert start without ack, then feed a second word s_in=0,1,1,0 with all c_in=1 -> result=4'h6, carry_count=4, last_carry=1.
- Full width: WIDTH=8 default, stream 0xA5 LSB first with all c_in=0 -> result=8'hA5, carry_count=0, last_carry=0, done after exactly 8 accepts.

Source files
------------

// File: rtl/serial_sum_collector.sv
// Deserialises the bit-serial adder's sum stream (LSB first) into a WIDTH-bit
// word, tallies carry events and flags word completion.
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   start           : begin (or restart) a word, clearing the accumulators
//   bit_valid       : s_in/c_in hold a valid bit this cycle
//   s_in, c_in      : sum and carry bits from the adder stage
//   ack             : consumer acknowledges a completed word
//   result          : deserialised word, bit 0 = first bit received
//   last_carry      : c_in captured with the final bit
//   carry_count     : accepted bits whose c_in was 1
//   bit_count       : bits accepted in the current word
//   busy / done     : decoded from state (CAPTURE / DONE)
module serial_sum_collector #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             s_in,
  input  logic             c_in,
  input  logic             ack,
  output logic [WIDTH-1:0] result,
  output logic             last_carry,
  output logic [CW-1:0]    carry_count,
  output logic [CW-1:0]    bit_count,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] CAPTURE = 2'b01;
  localparam logic [1:0] DONE    = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             last_carry_q, last_carry_d;
  logic [CW-1:0]    carry_count_q, carry_count_d;
  logic [CW-1:0]    bit_count_q, bit_count_d;

  // Next-state and accumulator update
  always_comb begin
    state_d       = state_q;
    result_d      = result_q;
    last_carry_d  = last_carry_q;
    carry_count_d = carry_count_q;
    bit_count_d   = bit_count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = CAPTURE;
          result_d      = '0;
          last_carry_d  = 1'b0;
          carry_count_d = '0;
          bit_count_d   = '0;
        end
      end

      CAPTURE: begin
        if (start) begin
          // Abort: the bit presented alongside start is discarded
          result_d      = '0;
          last_carry_d  = 1'b0;
          carry_count_d = '0;
          bit_count_d   = '0;
        end else if (bit_valid) begin
          // Right shift so the first bit ends up in bit 0
          result_d      = {s_in, result_q[WIDTH-1:1]};
          bit_count_d   = bit_count_q + CW'(1);
          carry_count_d = carry_count_q + CW'(c_in);
          if (bit_count_q == CW'(WIDTH - 1)) begin
            last_carry_d = c_in;
            state_d      = DONE;
          end
        end
      end

      DONE: begin
        if (start) begin
          state_d       = CAPTURE;
          result_d      = '0;
          last_carry_d  = 1'b0;
          carry_count_d = '0;
          bit_count_d   = '0;
        end else if (ack) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      result_q      <= '0;
      last_carry_q  <= 1'b0;
      carry_count_q <= '0;
      bit_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      result_q      <= result_d;
      last_carry_q  <= last_carry_d;
      carry_count_q <= carry_count_d;
      bit_count_q   <= bit_count_d;
    end
  end

  assign result      = result_q;
  assign last_carry  = last_carry_q;
  assign carry_count = carry_count_q;
  assign bit_count   = bit_count_q;
  assign busy        = (state_q == CAPTURE);
  assign done        = (state_q == DONE);

endmodule

// File: tb/tb_serial_sum_collector.sv
// Self-checking bench for serial_sum_collector: a WIDTH=4 and a default
// WIDTH=8 instance share one stimulus bus; completed 4-bit words are checked
// against a scoreboard of expectations pushed while driving.
module tb_serial_sum_collector;

  logic clk = 1'b0;
  logic reset, start, bit_valid, s_in, c_in, ack;

  logic [3:0] r4;  logic lc4;  logic [2:0] cc4, bc4;  logic busy4, done4;
  logic [7:0] r8;  logic lc8;  logic [3:0] cc8, bc8;  logic busy8, done8;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [3:0] res;
    int         cc;
    logic       lc;
  } exp_t;
  exp_t q4[$];
  bit   mon4_en = 1'b0;
  logic done4_prev = 1'b0;

  always #5 clk = ~clk;

  serial_sum_collector #(.WIDTH(4)) u4 (
    .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid),
    .s_in(s_in), .c_in(c_in), .ack(ack),
    .result(r4), .last_carry(lc4), .carry_count(cc4), .bit_count(bc4),
    .busy(busy4), .done(done4)
  );

  serial_sum_collector u8 (
    .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid),
    .s_in(s_in), .c_in(c_in), .ack(ack),
    .result(r8), .last_carry(lc8), .carry_count(cc8), .bit_count(bc8),
    .busy(busy8), .done(done8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_exp(input logic [3:0] s, input logic [3:0] c);
    exp_t e;
    e.res = s;
    e.cc  = 0;
    for (int i = 0; i < 4; i++) e.cc += int'(c[i]);
    e.lc  = c[3];
    q4.push_back(e);
  endtask

  // Feed one 4-bit word; optionally stall 3 cycles after bit index stall_after
  task automatic feed4(input logic [3:0] s, input logic [3:0] c, input int stall_after);
    for (int i = 0; i < 4; i++) begin
      s_in = s[i];
      c_in = c[i];
      bit_valid = 1'b1;
      tick();
      bit_valid = 1'b0;
      check($sformatf("done4_bit%0d", i), 32'(done4), 32'(i == 3));
      if (i == stall_after) begin
        for (int k = 0; k < 3; k++) begin
          tick();
          check("busy4_stall", 32'(busy4), 32'd1);
          check("bc4_stall", 32'(bc4), 32'(i + 1));
        end
      end
    end
  endtask

  // Scoreboard: compare on the rising edge of done
  always @(negedge clk) begin
    if (mon4_en && done4 && !done4_prev) begin
      if (q4.size() == 0) begin
        check("sb_empty", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        check("sb_result", 32'(r4), 32'(e.res));
        check("sb_carry_count", 32'(cc4), 32'(e.cc));
        check("sb_last_carry", 32'(lc4), 32'(e.lc));
        check("sb_bit_count", 32'(bc4), 32'd4);
        check("sb_busy", 32'(busy4), 32'd0);
      end
    end
    done4_prev <= done4;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; bit_valid = 1'b0; s_in = 1'b0; c_in = 1'b0; ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_result", 32'(r4), 32'd0);
    check("rst_busy_done", 32'({busy4, done4}), 32'd0);
    check("rst_counts", 32'({cc4, bc4, lc4}), 32'd0);
    mon4_en = 1'b1;

    // Reset mid-word
    pulse_start();
    check("busy_after_start", 32'(busy4), 32'd1);
    bit_valid = 1'b1; s_in = 1'b1; c_in = 1'b1;
    tick(); tick();
    bit_valid = 1'b0;
    check("bc_before_reset", 32'(bc4), 32'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_result", 32'(r4), 32'd0);
    check("midrst_bc", 32'(bc4), 32'd0);
    check("midrst_cc", 32'(cc4), 32'd0);
    check("midrst_busy_done", 32'({busy4, done4}), 32'd0);

    // Basic word then ack
    pulse_start();
    push_exp(4'b1101, 4'b1010);
    feed4(4'b1101, 4'b1010, -1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("ack_idle", 32'({busy4, done4}), 32'd0);
    check("ack_result_held", 32'(r4), 32'hD);
    // bit_valid ignored in IDLE
    bit_valid = 1'b1; s_in = 1'b0;
    tick();
    bit_valid = 1'b0;
    check("idle_ignore_bv", 32'(r4), 32'hD);

    // Stalls between bits 2 and 3
    pulse_start();
    push_exp(4'b1101, 4'b1010);
    feed4(4'b1101, 4'b1010, 1);
    ack = 1'b1; tick(); ack = 1'b0;

    // Abort/restart; the aborting-cycle bit must not be counted
    pulse_start();
    bit_valid = 1'b1; s_in = 1'b1; c_in = 1'b0;
    tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    bit_valid = 1'b0;
    check("abort_bc", 32'(bc4), 32'd0);
    check("abort_result", 32'(r4), 32'd0);
    check("abort_busy", 32'(busy4), 32'd1);
    push_exp(4'b1000, 4'b0000);
    feed4(4'b1000, 4'b0000, -1);

    // Back-to-back: start from DONE without ack
    pulse_start();
    check("b2b_cleared", 32'({r4, cc4, bc4}), 32'd0);
    push_exp(4'b0110, 4'b1111);
    feed4(4'b0110, 4'b1111, -1);

    // start wins over ack in DONE
    start = 1'b1; ack = 1'b1;
    tick();
    start = 1'b0; ack = 1'b0;
    check("start_over_ack", 32'({busy4, done4}), 32'b10);

    // Full width on the default instance
    mon4_en = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst8", 32'({r8, cc8, bc8, busy8, done8}), 32'd0);
    pulse_start();
    begin
      logic [7:0] w;
      w = 8'hA5;
      for (int i = 0; i < 8; i++) begin
        s_in = w[i]; c_in = 1'b0; bit_valid = 1'b1;
        tick();
        check($sformatf("done8_bit%0d", i), 32'(done8), 32'(i == 7));
      end
      bit_valid = 1'b0;
    end
    check("w8_result", 32'(r8), 32'hA5);
    check("w8_cc", 32'(cc8), 32'd0);
    check("w8_lc", 32'(lc8), 32'd0);
    check("w8_bc", 32'(bc8), 32'd8);

    tick();
    check("sb_drained", 32'(q4.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
